uart_rx_frame: RTL and testbench

- UART receiver on the host-link input pin (Uart_RXD).
- Converts 8N1 serial frames into bytes, delivered over a valid/ready handshake to the downstream command parser, which in turn drives the DAC8734/AD9910 SPI drivers.
- Adds start-bit glitch rejection, 3-sample majority voting, framing-error detection and overrun detection.
- Runs entirely in the 100 MHz system clock domain; the asynchronous pin is synchronised internally.

---
 rtl/uart_rx_frame_pkg.sv | 12 +
 rtl/uart_rx_frame_if.sv | 11 +
 rtl/uart_rx_frame_bit_synchronizer.sv | 25 ++
 rtl/uart_rx_frame.sv | 130 +++++++++++++
 tb/tb_uart_rx_frame.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_frame_pkg.sv
// Shared types and helpers for the host-link UART receiver.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 1736;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Valid/ready byte stream from the UART receiver to the command parser.
interface uart_rx_frame_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_frame_bit_synchronizer.sv
// Multi-flop synchroniser for asynchronous single-bit inputs (serial pins, buttons).
module bit_synchronizer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q[0] <= d;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver with start-glitch rejection, 3-sample majority voting,
// framing/overrun detection and a one-byte valid/ready holding register.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                   CLK100MHZ,
    input  logic                   reset,
    input  logic                   rxd,
    uart_rx_frame_if.master        rx_if,
    output logic                   frame_err,
    output logic                   overrun_err,
    output logic                   busy
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] SMP_A_C = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] SMP_B_C = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] MID_C   = CNT_W'(HALF + 1);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 smp_a;
    logic                 smp_b;
    logic                 deliver;
    logic                 rxd_s;
    logic                 rxd_s_d;
    logic                 bit_val;
    logic                 at_mid;
    logic                 at_wrap;

    bit_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_rxd_sync (
        .clk (CLK100MHZ),
        .rst (reset),
        .d   (rxd),
        .q   (rxd_s)
    );

    // Third vote is the live sample, so the bit resolves on the HALF+1 cycle itself.
    assign bit_val = maj3(smp_a, smp_b, rxd_s);
    assign at_mid  = (cnt == MID_C);
    assign at_wrap = (cnt == LAST_C);

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            shreg          <= '0;
            smp_a          <= 1'b0;
            smp_b          <= 1'b0;
            deliver        <= 1'b0;
            rxd_s_d        <= 1'b1;
            rx_if.rx_data  <= '0;
            rx_if.rx_valid <= 1'b0;
            frame_err      <= 1'b0;
            overrun_err    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            rxd_s_d     <= rxd_s;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            deliver     <= 1'b0;

            if (cnt == SMP_A_C) smp_a <= rxd_s;
            if (cnt == SMP_B_C) smp_b <= rxd_s;

            if (state == IDLE || at_wrap) cnt <= '0;
            else                          cnt <= cnt + CNT_W'(1);

            case (state)
                IDLE: begin
                    if (rxd_s_d && !rxd_s) begin
                        state   <= START;
                        busy    <= 1'b1;
                        bit_idx <= '0;
                    end
                end
                START: begin
                    if (at_mid && bit_val) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (at_wrap) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (at_mid) shreg[bit_idx] <= bit_val;
                    if (at_wrap) begin
                        if (bit_idx == IDX_LAST) state <= STOP;
                        else                     bit_idx <= bit_idx + IDX_W'(1);
                    end
                end
                STOP: begin
                    // Leave at mid-stop so the next start edge is never missed.
                    if (at_mid) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (bit_val) deliver   <= 1'b1;
                        else         frame_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (deliver) begin
                if (!rx_if.rx_valid || rx_if.rx_ready) begin
                    rx_if.rx_data  <= shreg;
                    rx_if.rx_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_if.rx_valid && rx_if.rx_ready) begin
                rx_if.rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: frames driven on rxd, delivered bytes popped and compared.
module tb_uart_rx_frame;
    localparam int CPB   = 160;
    localparam int FAST  = 155;
    localparam int SLOW  = 165;

    logic clk = 1'b0;
    logic rst;
    logic rxd;
    logic frame_err;
    logic overrun_err;
    logic busy;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int acc_cnt  = 0;
    int extra_cnt = 0;
    int fe0, ov0, acc0;
    logic [7:0] exp_q[$];

    uart_rx_frame_if #(.DATA_BITS(8)) rx_if ();

    uart_rx_frame #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .SYNC_STAGES  (2)
    ) dut (
        .CLK100MHZ   (clk),
        .reset       (rst),
        .rxd         (rxd),
        .rx_if       (rx_if.master),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err)   fe_cnt++;
            if (overrun_err) ov_cnt++;
            if (rx_if.rx_valid && rx_if.rx_ready) begin
                acc_cnt++;
                if (exp_q.size() == 0) extra_cnt++;
                else check("rx_data", 32'(rx_if.rx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int n);
        rxd = v;
        wait_clks(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input int per, input logic stop_v);
        drive_bit(1'b0, per);
        for (int i = 0; i < 8; i++) drive_bit(d[i], per);
        drive_bit(stop_v, per);
        rxd = 1'b1;
    endtask

    task automatic snap();
        fe0  = fe_cnt;
        ov0  = ov_cnt;
        acc0 = acc_cnt;
    endtask

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        rx_if.rx_ready = 1'b1;
        wait_clks(5);
        check("rst_busy",    32'(busy), 0);
        check("rst_valid",   32'(rx_if.rx_valid), 0);
        check("rst_data",    32'(rx_if.rx_data), 0);
        check("rst_ferr",    32'(frame_err), 0);
        check("rst_ovr",     32'(overrun_err), 0);
        rst = 1'b0;
        wait_clks(20);

        // Nominal byte
        snap();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, CPB, 1'b1);
        check("a5_busy_after_stop", 32'(busy), 0);
        wait_clks(CPB);
        check("a5_accepts", 32'(acc_cnt - acc0), 1);
        check("a5_ferr",    32'(fe_cnt - fe0), 0);
        check("a5_ovr",     32'(ov_cnt - ov0), 0);
        check("a5_valid_clear", 32'(rx_if.rx_valid), 0);

        // Start-bit glitch
        snap();
        drive_bit(1'b0, 46);
        rxd = 1'b1;
        wait_clks(CPB - 46);
        check("glitch_busy", 32'(busy), 0);
        wait_clks(2 * CPB);
        check("glitch_accepts", 32'(acc_cnt - acc0), 0);
        check("glitch_ferr",    32'(fe_cnt - fe0), 0);

        // Framing error then recovery
        snap();
        send_frame(8'h3C, CPB, 1'b0);
        wait_clks(CPB);
        check("fe_pulse_cycles", 32'(fe_cnt - fe0), 1);
        check("fe_accepts",      32'(acc_cnt - acc0), 0);
        check("fe_valid",        32'(rx_if.rx_valid), 0);
        snap();
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, CPB, 1'b1);
        wait_clks(CPB);
        check("fe_recover_accepts", 32'(acc_cnt - acc0), 1);
        check("fe_recover_ferr",    32'(fe_cnt - fe0), 0);

        // Overrun with consumer stalled
        snap();
        rx_if.rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, CPB, 1'b1);
        send_frame(8'h22, CPB, 1'b1);
        wait_clks(CPB);
        check("ovr_valid_held", 32'(rx_if.rx_valid), 1);
        check("ovr_data_held",  32'(rx_if.rx_data), 32'h11);
        check("ovr_pulses",     32'(ov_cnt - ov0), 1);
        check("ovr_no_accept",  32'(acc_cnt - acc0), 0);
        rx_if.rx_ready = 1'b1;
        wait_clks(1);
        rx_if.rx_ready = 1'b0;
        check("ovr_valid_fall", 32'(rx_if.rx_valid), 0);
        check("ovr_one_accept", 32'(acc_cnt - acc0), 1);
        wait_clks(4);
        check("ovr_valid_stays_low", 32'(rx_if.rx_valid), 0);
        rx_if.rx_ready = 1'b1;

        // Baud tolerance
        snap();
        foreach (exp_q[i]) extra_cnt += 0;
        for (int p = 0; p < 2; p++) begin
            int per;
            per = (p == 0) ? SLOW : FAST;
            exp_q.push_back(8'hFF);
            send_frame(8'hFF, per, 1'b1);
            wait_clks(per / 2);
            exp_q.push_back(8'h00);
            send_frame(8'h00, per, 1'b1);
            wait_clks(per / 2);
        end
        wait_clks(CPB);
        check("baud_accepts", 32'(acc_cnt - acc0), 4);
        check("baud_ferr",    32'(fe_cnt - fe0), 0);

        // Reset in the middle of data bit 4 of 0x77
        snap();
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(1'b1 & (8'h77 >> i), CPB);
        drive_bit(1'b1, CPB / 2);
        check("mid_busy_before_rst", 32'(busy), 1);
        rst = 1'b1;
        rxd = 1'b1;
        wait_clks(5);
        check("mid_rst_busy",  32'(busy), 0);
        check("mid_rst_valid", 32'(rx_if.rx_valid), 0);
        rst = 1'b0;
        wait_clks(20);
        exp_q.push_back(8'h0D);
        send_frame(8'h0D, CPB, 1'b1);
        wait_clks(CPB);
        check("mid_accepts", 32'(acc_cnt - acc0), 1);
        check("mid_ferr",    32'(fe_cnt - fe0), 0);
        check("mid_ovr",     32'(ov_cnt - ov0), 0);

        check("sb_leftover", 32'(exp_q.size()), 0);
        check("sb_extra",    32'(extra_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
